// File: rtl/alu_flags_pkg.sv
// Shared definitions for the ALU/flags stage: flag bit positions and slice geometry.
// The control sequencer relies on the same flag ordering.
package alu_flags_pkg;

  localparam int FLAGS_W = 4;
  localparam int FLAG_C  = 0;
  localparam int FLAG_Z  = 1;
  localparam int FLAG_N  = 2;
  localparam int FLAG_V  = 3;

  localparam int SLICE_W = 4;

  // Assembles the flag vector in the canonical bit order.
  function automatic logic [FLAGS_W-1:0] pack_flags(input logic c, input logic z,
                                                     input logic n, input logic v);
    logic [FLAGS_W-1:0] f;
    f         = '0;
    f[FLAG_C] = c;
    f[FLAG_Z] = z;
    f[FLAG_N] = n;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/alu_adder4.sv
// 4-bit ripple-carry adder slice; two of these chained form the 8-bit ALU.
module alu_adder4
  import alu_flags_pkg::*;
(
  input  logic [SLICE_W-1:0] a4,
  input  logic [SLICE_W-1:0] b4,
  input  logic               cin,
  output logic [SLICE_W-1:0] s4,
  output logic               cout
);

  logic [SLICE_W:0] carry;

  assign carry[0] = cin;

  for (genvar gi = 0; gi < SLICE_W; gi++) begin : g_bit
    assign s4[gi]       = a4[gi] ^ b4[gi] ^ carry[gi];
    assign carry[gi+1]  = (a4[gi] & b4[gi]) | (carry[gi] & (a4[gi] ^ b4[gi]));
  end

  assign cout = carry[SLICE_W];

endmodule

// File: rtl/alu_flags.sv
// Add/subtract stage between regA/regB and the shared bus, with a 4-bit
// flags register (carry, zero, negative, overflow) used by conditional jumps.
module alu_flags
  import alu_flags_pkg::*;
#(
  parameter int WIDTH = 8  // only 8 is supported: two fixed 4-bit slices
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             su,
  input  logic             eo_n,
  input  logic             fi_n,
  inout  wire  [WIDTH-1:0] bus,
  output logic [WIDTH-1:0] sum,
  output logic             cf,
  output logic             zf,
  output logic             nf,
  output logic             vf
);

  logic [7:0]         b_eff;
  logic               c4;
  logic               c8;
  logic               c7;
  logic               v_next;
  logic [FLAGS_W-1:0] flags_d;
  logic [FLAGS_W-1:0] flags_q;

  // Subtraction as A + ~B + 1; the +1 enters as the low slice carry-in.
  assign b_eff = B ^ {8{su}};

  alu_adder4 u_lo (
    .a4   (A[3:0]),
    .b4   (b_eff[3:0]),
    .cin  (su),
    .s4   (sum[3:0]),
    .cout (c4)
  );

  alu_adder4 u_hi (
    .a4   (A[7:4]),
    .b4   (b_eff[7:4]),
    .cin  (c4),
    .s4   (sum[7:4]),
    .cout (c8)
  );

  // Carry into bit 7 is recovered from the top sum bit; overflow is the
  // disagreement between carry into and out of the sign position.
  assign c7     = sum[7] ^ A[7] ^ b_eff[7];
  assign v_next = c7 ^ c8;

  assign bus = eo_n ? {WIDTH{1'bz}} : sum;

  always_comb begin
    flags_d = flags_q;
    if (!fi_n) begin
      flags_d = pack_flags(c8, (sum == 8'h00), sum[7], v_next);
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      flags_q <= '0;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign cf = flags_q[FLAG_C];
  assign zf = flags_q[FLAG_Z];
  assign nf = flags_q[FLAG_N];
  assign vf = flags_q[FLAG_V];

endmodule

// File: tb/tb_alu_flags.sv
// Directed-vector bench for alu_flags: stimulus queues expectations, a monitor
// process compares them against the DUT each time a check point is signalled.
module tb_alu_flags;

  typedef struct {
    string      name;
    int         kind;   // 0 = sum, 1 = bus, 2 = flags {v,n,z,c}
    logic [7:0] exp;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       su;
    logic       eo_n;
    logic       fi_n;
    logic [7:0] sum;
    logic [3:0] flags;  // {v,n,z,c}, hand-computed
  } vec_t;

  logic       clk = 1'b0;
  logic       clr;
  logic [7:0] A, B;
  logic       su, eo_n, fi_n;
  logic [7:0] sum;
  logic       cf, zf, nf, vf;
  wire  [7:0] bus;
  logic       drv_en;
  logic [7:0] drv_val;

  exp_t       sb_q[$];
  event       chk_ev;
  int         errors = 0;
  int         checks = 0;
  logic [3:0] model_flags;
  vec_t       vecs[11];

  assign bus = drv_en ? drv_val : 8'bz;

  alu_flags #(.WIDTH(8)) dut (
    .clk  (clk),
    .clr  (clr),
    .A    (A),
    .B    (B),
    .su   (su),
    .eo_n (eo_n),
    .fi_n (fi_n),
    .bus  (bus),
    .sum  (sum),
    .cf   (cf),
    .zf   (zf),
    .nf   (nf),
    .vf   (vf)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  // Monitor: drains every queued expectation at each check point.
  initial begin
    exp_t       e;
    logic [7:0] act;
    forever begin
      @(chk_ev);
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        case (e.kind)
          0:       act = sum;
          1:       act = bus;
          default: act = {4'b0000, vf, nf, zf, cf};
        endcase
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s: got %h required %h", e.name, act, e.exp);
        end
      end
    end
  end

  task automatic push(input string name, input int kind, input logic [7:0] exp);
    exp_t e;
    e.name = name;
    e.kind = kind;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic apply_vec(input int i);
    vec_t v;
    v = vecs[i];
    @(posedge clk);
    #2;
    A       = v.a;
    B       = v.b;
    su      = v.su;
    eo_n    = v.eo_n;
    fi_n    = v.fi_n;
    drv_en  = v.eo_n;
    drv_val = ~v.sum;
    #1;
    push($sformatf("v%0d_sum", i), 0, v.sum);
    push($sformatf("v%0d_bus", i), 1, v.eo_n ? ~v.sum : v.sum);
    push($sformatf("v%0d_flags_before", i), 2, {4'b0000, model_flags});
    ->chk_ev;
    $display("vec %0d: A=%h B=%h su=%0d eo_n=%0d fi_n=%0d exp_sum=%h exp_flags=%b",
             i, v.a, v.b, v.su, v.eo_n, v.fi_n, v.sum, model_flags);
    if (!v.fi_n) model_flags = v.flags;
  endtask

  initial begin
    vecs[0]  = '{8'h05, 8'h03, 1'b0, 1'b0, 1'b0, 8'h08, 4'b0000};
    vecs[1]  = '{8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 8'h00, 4'b0011};
    vecs[2]  = '{8'h7F, 8'h01, 1'b0, 1'b1, 1'b0, 8'h80, 4'b1100};
    vecs[3]  = '{8'h03, 8'h05, 1'b1, 1'b0, 1'b0, 8'hFE, 4'b0100};
    vecs[4]  = '{8'h05, 8'h05, 1'b1, 1'b0, 1'b0, 8'h00, 4'b0011};
    vecs[5]  = '{8'h80, 8'h01, 1'b1, 1'b1, 1'b0, 8'h7F, 4'b1001};
    vecs[6]  = '{8'h80, 8'h80, 1'b0, 1'b0, 1'b0, 8'h00, 4'b1011};
    vecs[7]  = '{8'h12, 8'h34, 1'b0, 1'b1, 1'b1, 8'h46, 4'b0000};
    vecs[8]  = '{8'hFF, 8'h00, 1'b1, 1'b0, 1'b1, 8'hFF, 4'b0101};
    vecs[9]  = '{8'h7F, 8'h7F, 1'b0, 1'b0, 1'b0, 8'hFE, 4'b1100};
    vecs[10] = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 4'b0010};

    clr = 1'b1; A = 8'h00; B = 8'h00; su = 1'b0;
    eo_n = 1'b1; fi_n = 1'b1; drv_en = 1'b0; drv_val = 8'h00;
    model_flags = 4'b0000;

    repeat (2) @(posedge clk);
    #1;
    push("reset_flags", 2, 8'h00);
    ->chk_ev;
    #1;
    clr = 1'b0;

    for (int i = 0; i <= 8; i++) apply_vec(i);

    // Flags hold 1011 here; assert clr between edges with fi_n low.
    @(posedge clk);
    #1;
    push("flags_before_clr", 2, {4'b0000, model_flags});
    ->chk_ev;
    #2;
    A = 8'h80; B = 8'h80; su = 1'b0; fi_n = 1'b0; eo_n = 1'b1; drv_en = 1'b1;
    clr = 1'b1;
    #1;
    push("clr_async", 2, 8'h00);
    ->chk_ev;
    $display("clr asserted mid-cycle, fi_n=0, A=80 B=80");
    @(posedge clk);
    #1;
    push("clr_dominates_fi", 2, 8'h00);
    ->chk_ev;
    #1;
    fi_n = 1'b1;
    clr  = 1'b0;
    model_flags = 4'b0000;

    for (int i = 9; i <= 10; i++) apply_vec(i);

    @(posedge clk);
    #1;
    push("final_flags_hold", 2, {4'b0000, model_flags});
    ->chk_ev;
    #1;

    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
